// File: rtl/nand_cpu_pkg.sv
// Shared types for the nand_cpu pipeline.
// Holds ALU op encoding, widths and the ID/EX bundle.
package nand_cpu_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int IMM_W     = 6;

  typedef enum logic [3:0] {
    ALU_CL   = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NAND = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_LI   = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t              alu_op;
    logic [DATA_W-1:0]    op0;
    logic [DATA_W-1:0]    op1;
    logic [REG_IDX_W-1:0] rd;
    logic                 wr_en;
    logic                 is_load;
  } id_ex_t;

  localparam id_ex_t ID_EX_RST = '{
    alu_op:  ALU_CL,
    op0:     '0,
    op1:     '0,
    rd:      '0,
    wr_en:   1'b0,
    is_load: 1'b0
  };

endpackage

// File: rtl/alu_input_ifc.sv
// Operand bundle from ID/EX register to the ALU.
// Modport out drives op0/op1/alu_op; in consumes them.
interface alu_input_ifc;
  import nand_cpu_pkg::*;

  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;
  alu_op_t           alu_op;

  modport out (output op0, output op1, output alu_op);
  modport in  (input op0, input op1, input alu_op);
endinterface

// File: rtl/fwd_mux.sv
// Operand bypass select: mem stage beats wb stage beats rf.
// Ports: rs index, rf data, two fwd sources, selected data.
module fwd_mux
  import nand_cpu_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [DATA_W-1:0]    rf_data,
  input  logic                 mem_fwd_valid,
  input  logic [REG_IDX_W-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0]    mem_fwd_data,
  input  logic                 wb_fwd_valid,
  input  logic [REG_IDX_W-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0]    wb_fwd_data,
  output logic [DATA_W-1:0]    data
);

  logic mem_hit;
  logic wb_hit;

  // r0 is an ordinary register here, so no zero-index guard.
  assign mem_hit = mem_fwd_valid && (mem_fwd_rd == rs);
  assign wb_hit  = wb_fwd_valid && (wb_fwd_rd == rs);

  always_comb begin
    data = rf_data;
    if (mem_hit) begin
      data = mem_fwd_data;
    end else if (wb_hit) begin
      data = wb_fwd_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bypass, load-use stall and flush.
// Ports: decode in (valid/ready), rf data, fwd, flush, ALU out.
module id_ex_stage
  import nand_cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  alu_op_t              in_alu_op,
  input  logic [REG_IDX_W-1:0] in_rs0,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic                 in_use_rs1,
  input  logic                 in_use_imm,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_wr_en,
  input  logic                 in_is_load,

  input  logic [DATA_W-1:0]    rf_data0,
  input  logic [DATA_W-1:0]    rf_data1,

  input  logic                 mem_fwd_valid,
  input  logic [REG_IDX_W-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0]    mem_fwd_data,
  input  logic                 wb_fwd_valid,
  input  logic [REG_IDX_W-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0]    wb_fwd_data,

  input  logic                 flush,

  output logic                 out_valid,
  input  logic                 out_ready,
  alu_input_ifc.out            alu_in,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wr_en,
  output logic                 out_is_load
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  id_ex_t q;
  id_ex_t d;

  logic [DATA_W-1:0] fwd0;
  logic [DATA_W-1:0] fwd1;
  logic              rs0_hit;
  logic              rs1_hit;
  logic              hazard;
  logic              accept;

  fwd_mux u_fwd0 (
    .rs            (in_rs0),
    .rf_data       (rf_data0),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .data          (fwd0)
  );

  fwd_mux u_fwd1 (
    .rs            (in_rs1),
    .rf_data       (rf_data1),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .data          (fwd1)
  );

  assign out_valid = (state_q == FULL);

  // Load data is not yet available to bypass while the load
  // sits in this register; hold the consumer one cycle.
  assign rs0_hit = (q.rd == in_rs0);
  assign rs1_hit = in_use_rs1 && !in_use_imm && (q.rd == in_rs1);
  assign hazard  = out_valid && q.is_load && q.wr_en
                && (rs0_hit || rs1_hit);

  assign in_ready = (!out_valid || out_ready) && !hazard
                 && !flush && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    d         = q;
    d.alu_op  = in_alu_op;
    d.op0     = fwd0;
    d.op1     = in_use_imm ? {{(DATA_W-IMM_W){1'b0}}, in_imm}
                           : fwd1;
    d.rd      = in_rd;
    d.wr_en   = in_wr_en;
    d.is_load = in_is_load;
  end

  always_comb begin
    state_d = EMPTY;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
    end else if (out_valid && !out_ready) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      q       <= ID_EX_RST;
    end else begin
      state_q <= state_d;
      if (accept) begin
        q <= d;
      end
    end
  end

  assign alu_in.op0    = q.op0;
  assign alu_in.op1    = q.op1;
  assign alu_in.alu_op = q.alu_op;
  assign out_rd        = q.rd;
  assign out_wr_en     = q.wr_en;
  assign out_is_load   = q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Scenario tasks check results inline and tally failures.
module tb_id_ex_stage;
  import nand_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     in_alu_op;
  logic [3:0]  in_rs0;
  logic [3:0]  in_rs1;
  logic        in_use_rs1;
  logic        in_use_imm;
  logic [5:0]  in_imm;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        in_is_load;
  logic [15:0] rf_data0;
  logic [15:0] rf_data1;
  logic        mem_fwd_valid;
  logic [3:0]  mem_fwd_rd;
  logic [15:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [3:0]  wb_fwd_rd;
  logic [15:0] wb_fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic        out_is_load;

  int total = 0;
  int bad   = 0;

  alu_input_ifc alu_if ();

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_rs0        (in_rs0),
    .in_rs1        (in_rs1),
    .in_use_rs1    (in_use_rs1),
    .in_use_imm    (in_use_imm),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_wr_en      (in_wr_en),
    .in_is_load    (in_is_load),
    .rf_data0      (rf_data0),
    .rf_data1      (rf_data1),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_in        (alu_if),
    .out_rd        (out_rd),
    .out_wr_en     (out_wr_en),
    .out_is_load   (out_is_load)
  );

  task automatic idle_inputs();
    in_valid = 0; in_alu_op = ALU_ADD;
    in_rs0 = 0; in_rs1 = 0; in_use_rs1 = 0;
    in_use_imm = 0; in_imm = 0; in_rd = 0;
    in_wr_en = 0; in_is_load = 0;
    rf_data0 = 0; rf_data1 = 0;
    mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    flush = 0; out_ready = 1;
  endtask

  // Advance one edge; outputs settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] rs0,
                       input logic [3:0] rs1,
                       input logic [3:0] rd,
                       input logic       ld);
    in_valid = 1; in_alu_op = ALU_ADD;
    in_rs0 = rs0; in_rs1 = rs1; in_use_rs1 = 1;
    in_use_imm = 0; in_rd = rd;
    in_wr_en = 1; in_is_load = ld;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    instr(4'd1, 4'd2, 4'd3, 1'b1);
    rf_data0 = 16'h1234;
    tick();
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_wr_en !== 1'b0
        || out_is_load !== 1'b0 || out_rd !== 4'd0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b%b%b rd=%h exp=000 rd=0",
               out_valid, out_wr_en, out_is_load, out_rd);
    end
    total++;
    if (alu_if.alu_op !== ALU_CL || alu_if.op0 !== 16'h0
        || alu_if.op1 !== 16'h0) begin
      bad++;
      $display("FAIL rst_ops got=%0d %h %h exp=0 0000 0000",
               alu_if.alu_op, alu_if.op0, alu_if.op1);
    end
    rst = 0;
    idle_inputs();
    #1;
  endtask

  task automatic test_fwd_priority();
    instr(4'd3, 4'd4, 4'd1, 1'b0);
    rf_data0 = 16'h1111; rf_data1 = 16'h4444;
    wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 16'h2222;
    mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 16'h3333;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fwd_in_ready got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || alu_if.op0 !== 16'h3333
        || alu_if.op1 !== 16'h4444) begin
      bad++;
      $display("FAIL fwd_mem got=%b %h %h exp=1 3333 4444",
               out_valid, alu_if.op0, alu_if.op1);
    end
    mem_fwd_valid = 0;
    tick();
    total++;
    if (alu_if.op0 !== 16'h2222) begin
      bad++;
      $display("FAIL fwd_wb got=%h exp=2222", alu_if.op0);
    end
    wb_fwd_valid = 0;
    tick();
    total++;
    if (alu_if.op0 !== 16'h1111) begin
      bad++;
      $display("FAIL fwd_rf got=%h exp=1111", alu_if.op0);
    end
    in_rs0 = 0; in_rs1 = 0;
    mem_fwd_valid = 1; mem_fwd_rd = 0; mem_fwd_data = 16'h0ABC;
    tick();
    total++;
    if (alu_if.op0 !== 16'h0ABC || alu_if.op1 !== 16'h0ABC) begin
      bad++;
      $display("FAIL fwd_r0 got=%h %h exp=0abc 0abc",
               alu_if.op0, alu_if.op1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_imm();
    instr(4'd2, 4'd5, 4'd7, 1'b0);
    in_alu_op = ALU_LI;
    in_use_imm = 1; in_imm = 6'b10_1010;
    rf_data1 = 16'hFFFF;
    mem_fwd_valid = 1; mem_fwd_rd = 5; mem_fwd_data = 16'h5555;
    tick();
    total++;
    if (alu_if.op1 !== 16'h002A || alu_if.alu_op !== ALU_LI
        || out_rd !== 4'd7) begin
      bad++;
      $display("FAIL imm got=%h %0d rd=%h exp=002a 9 rd=7",
               alu_if.op1, alu_if.alu_op, out_rd);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    instr(4'd1, 4'd2, 4'd5, 1'b1);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_is_load !== 1'b1) begin
      bad++;
      $display("FAIL lu_load got=%b%b exp=11",
               out_valid, out_is_load);
    end
    instr(4'd1, 4'd5, 4'd6, 1'b0);
    rf_data1 = 16'h0BAD;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL lu_stall got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lu_bubble got=%b exp=0", out_valid);
    end
    mem_fwd_valid = 1; mem_fwd_rd = 5; mem_fwd_data = 16'hBEEF;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lu_resume got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || alu_if.op1 !== 16'hBEEF
        || out_rd !== 4'd6) begin
      bad++;
      $display("FAIL lu_accept got=%b %h rd=%h exp=1 beef rd=6",
               out_valid, alu_if.op1, out_rd);
    end
  endtask

  // Entered FULL with rd=6, op1=BEEF from the load-use test.
  task automatic test_backpressure();
    instr(4'd2, 4'd8, 4'd7, 1'b0);
    rf_data0 = 16'h0022; rf_data1 = 16'h0088;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_rd !== 4'd6
          || alu_if.op1 !== 16'hBEEF) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=%b rd=%h %h exp=1 6 beef",
                 i, out_valid, out_rd, alu_if.op1);
      end
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_rd !== 4'd7
        || alu_if.op0 !== 16'h0022 || alu_if.op1 !== 16'h0088) begin
      bad++;
      $display("FAIL bp_next got=%b rd=%h %h %h exp=1 7 0022 0088",
               out_valid, out_rd, alu_if.op0, alu_if.op1);
    end
    idle_inputs();
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    instr(4'd1, 4'd2, 4'd1, 1'b0);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_rd !== 4'd1) begin
      bad++;
      $display("FAIL b2b_a got=%b rd=%h exp=1 1", out_valid, out_rd);
    end
    in_rd = 4'd2;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_rd !== 4'd2) begin
      bad++;
      $display("FAIL b2b_b got=%b rd=%h exp=1 2", out_valid, out_rd);
    end
  endtask

  task automatic test_flush();
    instr(4'd1, 4'd2, 4'd9, 1'b0);
    tick();
    instr(4'd1, 4'd2, 4'hA, 1'b0);
    flush = 1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fl_ready got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fl_kill got=%b exp=0", out_valid);
    end
    idle_inputs();
    tick();
    total++;
    if (out_valid !== 1'b0 || out_rd === 4'hA) begin
      bad++;
      $display("FAIL fl_noaccept got=%b rd=%h exp=0 rd!=a",
               out_valid, out_rd);
    end
  endtask

  task automatic test_reset_mid_stall();
    instr(4'd1, 4'd2, 4'd5, 1'b1);
    tick();
    instr(4'd5, 4'd2, 4'd3, 1'b0);
    out_ready = 0;
    rst = 1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rs_ready got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_rd !== 4'd0
        || out_is_load !== 1'b0) begin
      bad++;
      $display("FAIL rs_discard got=%b rd=%h ld=%b exp=0 0 0",
               out_valid, out_rd, out_is_load);
    end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_fwd_priority();
    test_imm();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
